// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute controller sequencing operand fetch, ALU execute and writeback
// for an 8-bit ALU; owns the W register and the C/Z status flags.
module alu_sequencer #(
    parameter int          FADDR_W = 7,
    parameter logic [7:0]  W_INIT  = 8'h00
) (
    input  logic               clk2,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [2:0]         req_bit,
    input  logic               req_lit,
    input  logic [7:0]         req_literal,
    input  logic [FADDR_W-1:0] req_faddr,
    input  logic               req_dest,
    output logic               rf_rd_en,
    output logic [FADDR_W-1:0] rf_addr,
    input  logic [7:0]         rf_rdata,
    output logic               rf_wr_en,
    output logic [7:0]         rf_wdata,
    output logic [3:0]         alu_inst,
    output logic [2:0]         alu_bit,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic               alu_we,
    input  logic [8:0]         alu_ans,
    output logic [7:0]         w_reg,
    output logic               status_c,
    output logic               status_z,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

    // One bit per opcode: which ALU operations affect Z and C respectively.
    localparam logic [15:0] Z_OPS = 16'h16FC;
    localparam logic [15:0] C_OPS = 16'h810C;

    state_t               state, state_nx;
    logic [3:0]           op_q;
    logic [2:0]           bit_q;
    logic                 lit_q, dest_q;
    logic [7:0]           literal_q, res;
    logic [FADDR_W-1:0]   faddr_q;

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rf_rd_en  = 1'b0;
        rf_wr_en  = 1'b0;
        rf_addr   = '0;
        rf_wdata  = 8'h00;
        alu_inst  = 4'h0;
        alu_bit   = 3'h0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_we    = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_lit ? EX : RD;
            end
            RD: begin
                rf_rd_en = 1'b1;
                rf_addr  = faddr_q;
                state_nx = EX;
            end
            EX: begin
                alu_inst = op_q;
                alu_bit  = bit_q;
                alu_a    = w_reg;
                alu_b    = lit_q ? literal_q : rf_rdata;
                alu_we   = 1'b1;
                state_nx = WB;
            end
            WB: begin
                done     = 1'b1;
                rf_wr_en = dest_q;
                rf_addr  = dest_q ? faddr_q : '0;
                rf_wdata = dest_q ? res : 8'h00;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            op_q      <= 4'h0;
            bit_q     <= 3'h0;
            lit_q     <= 1'b0;
            dest_q    <= 1'b0;
            literal_q <= 8'h00;
            faddr_q   <= '0;
            res       <= 8'h00;
            w_reg     <= W_INIT;
            status_c  <= 1'b0;
            status_z  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q      <= req_op;
                bit_q     <= req_bit;
                lit_q     <= req_lit;
                dest_q    <= req_dest;
                literal_q <= req_literal;
                faddr_q   <= req_faddr;
            end
            if (state == EX) begin
                res <= alu_ans[7:0];
                if (Z_OPS[op_q]) status_z <= (alu_ans[7:0] == 8'h00);
                if (C_OPS[op_q]) status_c <= alu_ans[8];
            end
            if (state == WB && !dest_q) w_reg <= res;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with a behavioural ALU and register file around the
// sequencer; expected results are queued at request time and checked when done pulses.
module tb_alu_sequencer;
    logic       clk2 = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_lit, req_dest;
    logic [3:0] req_op;
    logic [2:0] req_bit;
    logic [7:0] req_literal;
    logic [6:0] req_faddr;
    logic       rf_rd_en, rf_wr_en, alu_we, status_c, status_z, done;
    logic [6:0] rf_addr;
    logic [7:0] rf_rdata, rf_wdata, alu_a, alu_b, w_reg;
    logic [3:0] alu_inst;
    logic [2:0] alu_bit;
    logic [8:0] alu_ans;

    typedef struct {
        logic       dest;
        logic [6:0] faddr;
        logic [7:0] val;
        logic [7:0] w;
        logic       z;
        logic       c;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] rf_mem [128];
    logic [7:0] mfile [128];
    logic [7:0] mw;
    logic       mc, mz;

    always #5 clk2 = ~clk2;

    alu_sequencer #(.FADDR_W(7), .W_INIT(8'h00)) dut (
        .clk2(clk2), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_bit(req_bit),
        .req_lit(req_lit), .req_literal(req_literal), .req_faddr(req_faddr), .req_dest(req_dest),
        .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata),
        .alu_inst(alu_inst), .alu_bit(alu_bit), .alu_a(alu_a), .alu_b(alu_b),
        .alu_we(alu_we), .alu_ans(alu_ans),
        .w_reg(w_reg), .status_c(status_c), .status_z(status_z), .done(done)
    );

    // Reference ALU; carry bits of ops that must not touch C are deliberately non-trivial.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] n);
        logic [7:0] m;
        m = 8'd1 << n;
        case (op)
            4'd0:    return {1'b0, b};
            4'd1:    return {1'b1, a};
            4'd2:    return {1'b0, a} + {1'b0, b};
            4'd3:    return {1'b0, b} - {1'b0, a};
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {b == 8'h00, b - 8'd1};
            4'd7:    return {b == 8'hFF, b + 8'd1};
            4'd8:    return {b, b[7]};
            4'd9:    return {1'b0, a ^ b};
            4'd10:   return {1'b1, ~b};
            4'd11:   return {1'b0, b[3:0], b[7:4]};
            4'd12:   return 9'h100;
            4'd13:   return {1'b0, b | m};
            4'd14:   return {1'b1, b & ~m};
            default: return {b[0], 1'b0, b[7:1]};
        endcase
    endfunction

    always_comb alu_ans = alu_f(alu_inst, alu_a, alu_b, alu_bit);

    always @(posedge clk2) begin
        if (rf_wr_en) rf_mem[rf_addr] <= rf_wdata;
        if (rf_rd_en) rf_rdata <= rf_mem[rf_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [2:0] n, input logic l,
                         input logic [7:0] lv, input logic [6:0] fa, input logic d);
        logic [8:0] r;
        exp_t       e;
        r = alu_f(op, mw, l ? lv : mfile[fa], n);
        if (op inside {2, 3, 4, 5, 6, 7, 9, 10, 12}) mz = (r[7:0] == 8'h00);
        if (op inside {2, 3, 8, 15}) mc = r[8];
        if (d) mfile[fa] = r[7:0];
        else   mw = r[7:0];
        e.dest = d; e.faddr = fa; e.val = r[7:0]; e.w = mw; e.z = mz; e.c = mc;
        exp_q.push_back(e);
    endtask

    // Scoreboard: pop at each done pulse, check W one cycle later.
    exp_t cur;
    logic pend = 1'b0;
    always @(negedge clk2) begin
        if (reset) begin
            if (pend) begin
                chk("w_reg", 32'(w_reg), 32'(cur.w));
                pend = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rf_wr_en", 32'(rf_wr_en), 32'(cur.dest));
                    if (cur.dest) begin
                        chk("rf_addr_wb", 32'(rf_addr), 32'(cur.faddr));
                        chk("rf_wdata", 32'(rf_wdata), 32'(cur.val));
                    end
                    chk("status_z", 32'(status_z), 32'(cur.z));
                    chk("status_c", 32'(status_c), 32'(cur.c));
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [2:0] n, input logic l,
                          input logic [7:0] lv, input logic [6:0] fa, input logic d);
        int k;
        model(op, n, l, lv, fa, d);
        @(negedge clk2);
        req_valid = 1'b1; req_op = op; req_bit = n; req_lit = l;
        req_literal = lv; req_faddr = fa; req_dest = d;
        k = 0;
        while (!req_ready && k < 10) begin @(negedge clk2); k++; end
        chk("accept_wait", 32'(k < 10), 32'd1);
        @(negedge clk2);
        req_valid = 1'b0;
        req_op = 4'($urandom); req_bit = 3'($urandom); req_lit = 1'($urandom);
        req_literal = 8'($urandom); req_faddr = 7'($urandom); req_dest = 1'($urandom);
        chk("rd_en_first", 32'(rf_rd_en), 32'(!l));
        if (!l) chk("rd_addr", 32'(rf_addr), 32'(fa));
        else    chk("alu_we_lit", 32'(alu_we), 32'd1);
        k = 1;
        while (!done && k < 10) begin @(negedge clk2); k++; end
        chk("latency", 32'(k), l ? 32'd2 : 32'd3);
        @(negedge clk2);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin rf_mem[i] = 8'h00; mfile[i] = 8'h00; end
        mw = 8'h00; mc = 1'b0; mz = 1'b0;
        reset = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_bit = 3'h0;
        req_lit = 1'b0; req_literal = 8'h00; req_faddr = 7'h00; req_dest = 1'b0;
        repeat (2) @(negedge clk2);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_w", 32'(w_reg), 32'h00);
        chk("rst_flags", 32'({status_c, status_z}), 32'd0);
        chk("rst_strobes", 32'({done, rf_rd_en, rf_wr_en, alu_we}), 32'd0);
        chk("rst_alu", 32'({alu_inst, alu_bit, alu_a, alu_b}), 32'd0);
        reset = 1'b1;
        // Reset during EX of a file op must abandon it completely.
        @(negedge clk2);
        req_valid = 1'b1; req_op = 4'd10; req_lit = 1'b0; req_faddr = 7'd1; req_dest = 1'b1;
        @(negedge clk2);
        req_valid = 1'b0;
        @(negedge clk2);
        chk("mid_ex_we", 32'(alu_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_strobes", 32'({done, rf_wr_en, alu_we}), 32'd0);
        @(negedge clk2);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk2);
            chk("abort_quiet", 32'({done, rf_wr_en}), 32'd0);
        end
        chk("abort_w", 32'(w_reg), 32'h00);
        chk("abort_flags", 32'({status_c, status_z}), 32'd0);
        chk("abort_file", 32'(rf_mem[1]), 32'h00);
        // Literal add with wrap, then file subtract with borrow.
        run_op(4'd0, 3'd0, 1'b1, 8'h0F, 7'd0, 1'b0);
        run_op(4'd2, 3'd0, 1'b1, 8'hF1, 7'd0, 1'b0);
        run_op(4'd0, 3'd0, 1'b1, 8'h03, 7'd5, 1'b1);
        run_op(4'd0, 3'd0, 1'b1, 8'h05, 7'd0, 1'b0);
        run_op(4'd3, 3'd0, 1'b0, 8'h00, 7'd5, 1'b1);
        // Bit set into file then move to W; neither touches flags.
        run_op(4'd13, 3'd7, 1'b0, 8'h00, 7'd2, 1'b1);
        run_op(4'd0, 3'd0, 1'b0, 8'h00, 7'd2, 1'b0);
        run_op(4'd1, 3'd0, 1'b0, 8'h00, 7'd0, 1'b0);
        run_op(4'd14, 3'd7, 1'b0, 8'h00, 7'd2, 1'b1);
        run_op(4'd2, 3'd0, 1'b1, 8'h00, 7'd0, 1'b0);
        // Decrement to zero and below zero; C must stay put.
        run_op(4'd6, 3'd0, 1'b1, 8'h01, 7'd0, 1'b0);
        run_op(4'd6, 3'd0, 1'b1, 8'h00, 7'd0, 1'b0);
        run_op(4'd8, 3'd0, 1'b1, 8'h81, 7'd0, 1'b0);
        // Continuous request: one accept every 4 cycles, back-to-back read-after-write.
        repeat (3) model(4'd7, 3'd0, 1'b0, 8'h00, 7'd10, 1'b1);
        @(negedge clk2);
        req_valid = 1'b1; req_op = 4'd7; req_bit = 3'd0; req_lit = 1'b0;
        req_literal = 8'h00; req_faddr = 7'd10; req_dest = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk2);
            chk("stream_ready", 32'(req_ready), 32'(i % 4 == 0));
            chk("stream_done", 32'(done), 32'(i % 4 == 3));
        end
        req_valid = 1'b0;
        @(negedge clk2);
        run_op(4'd0, 3'd0, 1'b0, 8'h00, 7'd10, 1'b0);
        run_op(4'd12, 3'd0, 1'b0, 8'h00, 7'd0, 1'b1);
        run_op(4'd15, 3'd0, 1'b0, 8'h00, 7'd5, 1'b0);
        repeat (2) @(negedge clk2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
